// File: rtl/char_arb_pkg.sv
// ---------------------------------------------------------------------------
// char_arb_pkg
//
// Shared definitions for the multi-core UART character arbiter: default
// parameter values used by both the per-requester FIFO and the top level,
// and the encoding of the arbiter's issue state machine.
//
// No ports (package only).
// ---------------------------------------------------------------------------
package char_arb_pkg;

   // Default configuration: four cores, 8-bit characters, 4-deep FIFOs.
   localparam int DEFAULT_NUM_REQUESTERS = 4;
   localparam int DEFAULT_CHAR_BITS      = 8;
   localparam int DEFAULT_FIFO_DEPTH     = 4;

   // Issue state machine:
   //   ARB_IDLE  - waiting for a queued character and a ready UART
   //   ARB_ISSUE - out_char_en is high for exactly this cycle
   //   ARB_GAP   - one dead cycle so the UART can drop its ready flag
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_GAP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/char_fifo.sv
// ---------------------------------------------------------------------------
// char_fifo
//
// Small synchronous FIFO holding the characters written by one core until
// the arbiter gets round to sending them. Full/empty come straight from the
// registered occupancy count, so a core's ready flag never depends on the
// write pulse arriving in the same cycle.
//
// Ports:
//   clk        - clock
//   reset_n    - synchronous active-low reset, empties the FIFO
//   push       - write request (one-cycle pulse from the core)
//   pop        - read request from the arbiter (only issued when not empty)
//   push_data  - character to write
//   pop_data   - character at the head of the FIFO
//   full       - FIFO holds FIFO_DEPTH characters
//   empty      - FIFO holds no characters
//   drop       - push attempted while full; the character is lost
// ---------------------------------------------------------------------------
module char_fifo
   import char_arb_pkg::*;
#(
   parameter int CHAR_BITS  = DEFAULT_CHAR_BITS,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 push,
   input  logic                 pop,
   input  logic [CHAR_BITS-1:0] push_data,
   output logic [CHAR_BITS-1:0] pop_data,
   output logic                 full,
   output logic                 empty,
   output logic                 drop
);

   localparam int PTR_BITS = $clog2(FIFO_DEPTH);
   localparam logic [PTR_BITS:0] DEPTH_COUNT = (PTR_BITS + 1)'(FIFO_DEPTH);

   logic [CHAR_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_BITS-1:0]  wr_ptr;
   logic [PTR_BITS-1:0]  rd_ptr;
   logic [PTR_BITS:0]    count;
   logic                 push_ok;
   logic                 pop_ok;

   // The full test uses the count from before this cycle's pop, so a push
   // into a full FIFO is dropped even if the arbiter drains it on the same
   // edge. That keeps the drop decision independent of arbitration timing.
   assign full     = (count == DEPTH_COUNT);
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign drop     = push && full;
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping. Pointers are exactly log2(depth)
   // bits wide so they wrap on their own; the count carries one extra bit
   // to tell full apart from empty.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Character storage. Contents need no reset: after reset the pointers
   // say the FIFO is empty, so stale entries are never read.
   always_ff @(posedge clk) begin
      if (reset_n && push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/uart_char_arbiter.sv
// ---------------------------------------------------------------------------
// uart_char_arbiter
//
// Lets several picorv32 cores share one UART character output. Each core's
// character write lands in its own FIFO; a round-robin scheduler drains the
// FIFOs one character at a time. A character takes three cycles to send
// (IDLE -> ISSUE -> GAP), the gap giving the UART time to drop its ready
// flag after accepting a character.
//
// Ports:
//   clk             - clock
//   reset_n         - synchronous active-low reset
//   req_char        - packed characters, requester i at [i*CHAR_BITS +: CHAR_BITS]
//   req_char_en     - one-cycle write pulse per requester
//   req_char_ready  - per requester: its FIFO can take another character
//   req_overflow    - per requester: sticky, a character was dropped
//   out_char        - character presented to the UART
//   out_char_en     - one-cycle issue pulse to the UART
//   out_char_ready  - UART can accept a character
//   grant_id        - requester that supplied the most recent character
// ---------------------------------------------------------------------------
module uart_char_arbiter
   import char_arb_pkg::*;
#(
   parameter int NUM_REQUESTERS = DEFAULT_NUM_REQUESTERS,
   parameter int CHAR_BITS      = DEFAULT_CHAR_BITS,
   parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [NUM_REQUESTERS*CHAR_BITS-1:0] req_char,
   input  logic [NUM_REQUESTERS-1:0]           req_char_en,
   output logic [NUM_REQUESTERS-1:0]           req_char_ready,
   output logic [NUM_REQUESTERS-1:0]           req_overflow,
   output logic [CHAR_BITS-1:0]                out_char,
   output logic                                out_char_en,
   input  logic                                out_char_ready,
   output logic [$clog2(NUM_REQUESTERS)-1:0]   grant_id
);

   localparam int ID_BITS = $clog2(NUM_REQUESTERS);
   localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_REQUESTERS - 1);

   arb_state_t state;
   arb_state_t next_state;

   logic [NUM_REQUESTERS-1:0] fifo_full;
   logic [NUM_REQUESTERS-1:0] fifo_empty;
   logic [NUM_REQUESTERS-1:0] fifo_drop;
   logic [NUM_REQUESTERS-1:0] fifo_pop;
   logic [CHAR_BITS-1:0]      fifo_data [NUM_REQUESTERS];

   logic [ID_BITS-1:0] last_grant;
   logic [ID_BITS-1:0] winner;
   logic [ID_BITS-1:0] cand;
   logic               any_pending;
   logic               grant;
   logic               issue_next;

   // One FIFO per core. A push into a full FIFO is reported back through
   // drop and latched into that core's sticky overflow flag below.
   for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_fifo
      char_fifo #(
         .CHAR_BITS  (CHAR_BITS),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .reset_n   (reset_n),
         .push      (req_char_en[i]),
         .pop       (fifo_pop[i]),
         .push_data (req_char[i*CHAR_BITS +: CHAR_BITS]),
         .pop_data  (fifo_data[i]),
         .full      (fifo_full[i]),
         .empty     (fifo_empty[i]),
         .drop      (fifo_drop[i])
      );
   end

   // A core may write whenever its FIFO has room. This depends only on the
   // registered count, never on the core's own write pulse.
   assign req_char_ready = ~fifo_full;

   // Round-robin selection: scan starting just after the last winner and
   // take the first non-empty FIFO. The last winner is scanned last, so a
   // busy core cannot shut out the others and every non-empty FIFO is
   // served within NUM_REQUESTERS grants.
   always_comb begin
      any_pending = 1'b0;
      winner      = '0;
      cand        = '0;
      for (int k = 1; k <= NUM_REQUESTERS; k++) begin
         cand = ID_BITS'((int'(last_grant) + k) % NUM_REQUESTERS);
         if (!any_pending && !fifo_empty[cand]) begin
            any_pending = 1'b1;
            winner      = cand;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ARB_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next-state logic. ISSUE and GAP last one cycle each; the UART's
   // ready flag is only looked at in IDLE because it may still be high in
   // the cycle right after it accepted a character.
   always_comb begin
      next_state = state;
      case (state)
         ARB_IDLE: begin
            if (out_char_ready && any_pending) begin
               next_state = ARB_ISSUE;
            end
         end
         ARB_ISSUE: next_state = ARB_GAP;
         ARB_GAP:   next_state = ARB_IDLE;
         default:   next_state = ARB_IDLE;
      endcase
   end

   // FSM output decode. The grant happens on the IDLE -> ISSUE edge: the
   // winner's FIFO is popped on that same edge while its head character is
   // captured into out_char, so the character is on the bus throughout the
   // ISSUE cycle.
   always_comb begin
      grant      = (state == ARB_IDLE) && out_char_ready && any_pending;
      issue_next = (next_state == ARB_ISSUE);
      fifo_pop   = '0;
      if (grant) begin
         fifo_pop[winner] = 1'b1;
      end
   end

   // Registered outputs. out_char and grant_id are only updated on a grant
   // and otherwise hold the last issued character. last_grant starts at the
   // highest index so requester 0 wins the first contest after reset.
   // Reset also kills an issue pulse that would otherwise follow.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_char     <= '0;
         out_char_en  <= 1'b0;
         grant_id     <= '0;
         last_grant   <= LAST_ID;
         req_overflow <= '0;
      end else begin
         out_char_en  <= issue_next;
         req_overflow <= req_overflow | fifo_drop;
         if (grant) begin
            out_char   <= fifo_data[winner];
            grant_id   <= winner;
            last_grant <= winner;
         end
      end
   end

endmodule

// File: doc/uart_char_arbiter.md
# uart_char_arbiter

Shares the single UART character output (`out_char` / `out_char_en` / `out_char_ready`) between several picorv32 cores in the multi-core system. Each core's `CHAR_OUTPUT` write pulse is pushed into a per-core FIFO. A round-robin scheduler drains the FIFOs one character at a time into the UART. Each core polls its per-core ready flag through its `CHAR_OUTPUT_READY_INPUT` address, exactly as the single-core system polls `out_char_ready`.

## Interface
Parameters:
- `NUM_REQUESTERS`, 4: number of cores sharing the UART; range 2–16.
- `CHAR_BITS`, 8: character width.
- `FIFO_DEPTH`, 4: entries per requester FIFO; must be a power of 2, at least 2.

Ports:
- `clk`  in  1: the only clock.
- `reset_n`  in  1: reset, synchronous, active-low.
- `req_char`  in  NUM_REQUESTERS*CHAR_BITS: requester i's character at bits [i*CHAR_BITS +: CHAR_BITS].
- `req_char_en`  in  NUM_REQUESTERS: one-cycle write pulse per requester.
- `req_char_ready`  out  NUM_REQUESTERS: high when requester i's FIFO is not full.
- `req_overflow`  out  NUM_REQUESTERS: sticky flag; set when a push was dropped; cleared only by reset.
- `out_char`  out  CHAR_BITS: character to the UART.
- `out_char_en`  out  1: one-cycle issue pulse to the UART.
- `out_char_ready`  in  1: UART can accept a character.
- `grant_id`  out  $clog2(NUM_REQUESTERS): source of the most recently issued character.

## Operation
- Reset values (first edge with reset_n=0):
  - `out_char`=0, `out_char_en`=0, `grant_id`=0, `req_overflow`=0.
  - All FIFOs empty, so `req_char_ready` is all ones after that edge.
  - FSM goes to IDLE.
  - Round-robin pointer `last_grant` = NUM_REQUESTERS-1, so requester 0 has top priority first.
- Push:
  - When `req_char_en[i]` is high and FIFO i is not full (registered count, sampled before any same-cycle pop), the character is written.
  - When FIFO i is full, the push is dropped and `req_overflow[i]` is set. This holds even if a pop of FIFO i happens in the same cycle.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE → ISSUE when `out_char_ready`=1 and at least one FIFO is non-empty.
    - Winner = first non-empty requester scanning `last_grant`+1, +2, … modulo NUM_REQUESTERS.
    - In the same edge: pop the winner's FIFO, register `out_char`, set `grant_id` and `last_grant` to the winner.
  - ISSUE: `out_char_en`=1 for exactly this one cycle. Always → GAP.
  - GAP: `out_char_en`=0; `out_char_ready` is ignored, since the UART deasserts ready in the cycle after accepting. Always → IDLE.
  - IDLE with `out_char_ready`=0 or all FIFOs empty: stay in IDLE.
- `out_char` and `grant_id` hold their values after ISSUE until the next grant.
- Non-empty requesters are never starved: any non-empty requester is granted within NUM_REQUESTERS grants.
- Pointer arithmetic:
  - FIFO read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Count is $clog2(FIFO_DEPTH)+1 bits; full when count == FIFO_DEPTH.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
- Reset mid-operation:
  - All FIFO contents are discarded.
  - A pending ISSUE is aborted: `out_char_en` is 0 in the cycle after the reset edge.

## Timing
- Latency: `req_char_en` high in cycle 0, with the arbiter in IDLE, the FIFO empty and `out_char_ready`=1 in cycle 1 → `out_char_en` high in cycle 2.
- Throughput: at most one character per 3 cycles (IDLE, ISSUE, GAP).
- `req_char_ready` is combinational from the registered count only; there is no path from `req_char_en` to it.
- All outputs are registered except `req_char_ready`.

## Structure
- Shared package `char_arb_pkg`:
  - FSM state encoding (`ARB_IDLE`, `ARB_ISSUE`, `ARB_GAP`).
  - Default parameter values.
- Sub-module `char_fifo`, one instance per requester:
  - Parameters CHAR_BITS and FIFO_DEPTH.
  - Ports: push, pop, data in/out, full, empty, and a drop pulse.
- Top level holds the round-robin selector and the FSM.

## Test plan
- Single char: requester 2 pushes 0x41 with ready=1 → `out_char`=0x41 and `grant_id`=2, `out_char_en` high exactly 2 cycles after the push.
- Fair contention: requesters 0–3 each push one char ('a','b','c','d') in the same cycle → issued in order a, b, c, d on consecutive ISSUE cycles spaced 3 cycles apart.
- Round-robin wrap: after requester 3 is granted, requesters 1 and 3 both non-empty → requester 1 is granted before requester 3.
- Backpressure: `out_char_ready`=0 for 20 cycles with 2 chars queued → no `out_char_en`; both issue after ready rises, order preserved.
- Overflow: requester 1 pushes 5 chars with ready=0 (FIFO_DEPTH=4) → `req_char_ready[1]`=0 after the 4th push, 5th char dropped, `req_overflow[1]`=1, only 4 chars later issued.
- Reset mid-issue: reset_n=0 on the ISSUE cycle with 3 chars queued → no further `out_char_en`, `req_char_ready` all ones, `req_overflow`=0.
